// File: rtl/panel_scan_matrix.sv
// Front-panel LED/switch matrix scanner: time-multiplexes LED rows with per-row PWM onto shared
// columns, then scans switch rows and debounces them over whole frames.
`timescale 1ns / 1ps
module panel_scan_matrix #(
  parameter int unsigned N_LED_ROWS   = 8,
  parameter int unsigned N_SW_ROWS    = 3,
  parameter int unsigned N_COLS       = 12,
  parameter int unsigned DISPLAY_TIME = 100000,
  parameter int unsigned PAUSE_TIME   = 500,
  parameter int unsigned SW_TIME      = 500,
  parameter int unsigned DB_FRAMES    = 3,
  parameter int unsigned BRIGHT_BITS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_LED_ROWS*N_COLS-1:0]    led_data,
  input  logic [BRIGHT_BITS-1:0]          led_bright,
  output logic [N_LED_ROWS-1:0]           led_row_o,
  output logic                            led_row_oe,
  output logic [N_COLS-1:0]               col_o,
  output logic                            col_oe,
  input  logic [N_COLS-1:0]               col_i,
  output logic [N_SW_ROWS-1:0]            sw_row_oe,
  output logic [N_SW_ROWS*N_COLS-1:0]     sw_state,
  output logic [N_SW_ROWS*N_COLS-1:0]     sw_rise,
  output logic                            sw_valid,
  output logic                            frame_start
);

  localparam int unsigned TMax = (DISPLAY_TIME > SW_TIME) ? DISPLAY_TIME : SW_TIME;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;
  localparam int unsigned RMax = (N_LED_ROWS > N_SW_ROWS) ? N_LED_ROWS : N_SW_ROWS;
  localparam int unsigned RW   = (RMax > 1) ? $clog2(RMax) : 1;
  localparam int unsigned NB   = N_SW_ROWS * N_COLS;
  localparam int unsigned CW   = (DB_FRAMES > 1) ? $clog2(DB_FRAMES) : 1;

  typedef enum logic [1:0] {StLed, StSw, StUpdate} phase_e;

  phase_e                 phase_q, phase_d;
  logic [TW-1:0]          t_q, t_d;
  logic [RW-1:0]          row_q, row_d;
  logic [N_COLS-1:0]      row_cap_q;
  logic [BRIGHT_BITS-1:0] bright_cap_q;
  logic [N_COLS-1:0]      sync1_q, sync2_q;
  logic [NB-1:0]          raw_q, raw_d;
  logic [NB-1:0]          sw_state_q, sw_state_d;
  logic [NB-1:0]          sw_rise_q, sw_rise_d;
  logic                   sw_valid_q, sw_valid_d;
  logic [CW-1:0]          cnt_q [NB];
  logic [CW-1:0]          cnt_d [NB];

  logic                   led_last, sw_last, led_row_last, sw_row_last, slot_start;
  logic [N_COLS-1:0]      row_live, row_eff;
  logic [BRIGHT_BITS-1:0] bright_eff, pwm_cnt;
  logic [31:0]            t32;
  logic                   in_window, pwm_on;

  assign led_last     = (t_q == TW'(DISPLAY_TIME - 1));
  assign sw_last      = (t_q == TW'(SW_TIME - 1));
  assign led_row_last = (row_q == RW'(N_LED_ROWS - 1));
  assign sw_row_last  = (row_q == RW'(N_SW_ROWS - 1));
  assign slot_start   = (phase_q == StLed) && (t_q == '0);

  always_comb begin
    phase_d = phase_q;
    t_d     = t_q + 1'b1;
    row_d   = row_q;
    case (phase_q)
      StLed: begin
        if (led_last) begin
          t_d = '0;
          if (led_row_last) begin
            row_d   = '0;
            phase_d = StSw;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StSw: begin
        if (sw_last) begin
          t_d = '0;
          if (sw_row_last) begin
            row_d   = '0;
            phase_d = StUpdate;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: begin
        phase_d = StLed;
        t_d     = '0;
        row_d   = '0;
      end
    endcase
  end

  always_comb begin
    row_live = '0;
    for (int r = 0; r < N_LED_ROWS; r++) begin
      if (row_q == RW'(r)) row_live = led_data[r*N_COLS +: N_COLS];
    end
  end

  // In the capture cycle itself the live inputs stand in for the not-yet-loaded registers.
  assign row_eff    = slot_start ? row_live   : row_cap_q;
  assign bright_eff = slot_start ? led_bright : bright_cap_q;

  assign t32       = 32'(t_q);
  assign in_window = (phase_q == StLed) && (t32 >= PAUSE_TIME) &&
                     (t32 < DISPLAY_TIME - PAUSE_TIME);
  assign pwm_cnt   = BRIGHT_BITS'(t32 - PAUSE_TIME);
  assign pwm_on    = (&bright_eff) || (pwm_cnt < bright_eff);

  // Outputs decode from the scan position; rst_n gates them so reset blanks the pads at once.
  always_comb begin
    led_row_o   = '0;
    led_row_oe  = 1'b0;
    col_o       = '0;
    col_oe      = 1'b0;
    sw_row_oe   = '0;
    frame_start = 1'b0;
    if (rst_n) begin
      case (phase_q)
        StLed: begin
          for (int r = 0; r < N_LED_ROWS; r++) led_row_o[r] = (row_q == RW'(r));
          col_o       = ~row_eff;
          col_oe      = in_window && pwm_on;
          led_row_oe  = in_window && pwm_on;
          frame_start = (row_q == '0) && (t_q == '0);
        end
        StSw: begin
          for (int s = 0; s < N_SW_ROWS; s++) sw_row_oe[s] = (row_q == RW'(s));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    raw_d = raw_q;
    if ((phase_q == StSw) && sw_last) begin
      for (int s = 0; s < N_SW_ROWS; s++) begin
        if (row_q == RW'(s)) raw_d[s*N_COLS +: N_COLS] = ~sync2_q;
      end
    end
  end

  always_comb begin
    sw_state_d = sw_state_q;
    sw_rise_d  = '0;
    sw_valid_d = 1'b0;
    for (int b = 0; b < NB; b++) cnt_d[b] = cnt_q[b];
    if (phase_q == StUpdate) begin
      sw_valid_d = 1'b1;
      for (int b = 0; b < NB; b++) begin
        if (raw_q[b] == sw_state_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == CW'(DB_FRAMES - 1)) begin
          sw_state_d[b] = raw_q[b];
          sw_rise_d[b]  = raw_q[b];
          cnt_d[b]      = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= StLed;
      t_q          <= '0;
      row_q        <= '0;
      row_cap_q    <= '0;
      bright_cap_q <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      raw_q        <= '0;
      sw_state_q   <= '0;
      sw_rise_q    <= '0;
      sw_valid_q   <= 1'b0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
    end else begin
      phase_q    <= phase_d;
      t_q        <= t_d;
      row_q      <= row_d;
      sync1_q    <= col_i;
      sync2_q    <= sync1_q;
      raw_q      <= raw_d;
      sw_state_q <= sw_state_d;
      sw_rise_q  <= sw_rise_d;
      sw_valid_q <= sw_valid_d;
      cnt_q      <= cnt_d;
      if (slot_start) begin
        row_cap_q    <= row_live;
        bright_cap_q <= led_bright;
      end
    end
  end

  assign sw_state = sw_state_q;
  assign sw_rise  = sw_rise_q;
  assign sw_valid = sw_valid_q;

endmodule

// File: doc/panel_scan_matrix.md
Name: panel_scan_matrix

Overview:
- Parametrised LED/switch matrix scanner for front-panel hardware; successor to the fixed 8-LED-row/3-switch-row/12-column panel driver.
- Time-multiplexes N_LED_ROWS of LED data onto shared columns, then scans N_SW_ROWS of switches on the same columns.
- New over the previous driver: per-row PWM brightness, frame-counted debounce, rise-edge strobes and a frame-valid pulse.
- Pads are split into o/oe/i signals; the board top instantiates the IO buffers and pull-ups.

Parameters:
- N_LED_ROWS, 8, number of LED rows.
- N_SW_ROWS, 3, number of switch rows.
- N_COLS, 12, shared column count.
- DISPLAY_TIME, 100000, cycles per LED row slot.
- PAUSE_TIME, 500, blanking cycles at each end of an LED slot; requires 2*PAUSE_TIME < DISPLAY_TIME.
- SW_TIME, 500, cycles per switch row slot; requires SW_TIME >= 4.
- DB_FRAMES, 3, number of consecutive differing frames needed to accept a switch change; requires DB_FRAMES >= 1.
- BRIGHT_BITS, 4, brightness resolution.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- led_data  in  N_LED_ROWS*N_COLS  row r is bits [r*N_COLS +: N_COLS]; 1 = lit.
- led_bright  in  BRIGHT_BITS  global brightness.
- led_row_o  out  N_LED_ROWS  one-hot, active-high row drive.
- led_row_oe  out  1  LED row output enable.
- col_o  out  N_COLS  active-low column drive.
- col_oe  out  1  column output enable.
- col_i  in  N_COLS  column pad input, asynchronous, pulled up on the board.
- sw_row_oe  out  N_SW_ROWS  open-drain enables; the pad drives 0 when the bit is 1.
- sw_state  out  N_SW_ROWS*N_COLS  debounced switch state; 1 = closed.
- sw_rise  out  N_SW_ROWS*N_COLS  bits that became 1 this frame; valid with sw_valid.
- sw_valid  out  1  one-cycle pulse per frame.
- frame_start  out  1  one-cycle pulse in the first cycle of LED row 0.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - All debounce counters 0.
  - Scan begins at LED row 0, slot offset 0.
- Frame sequence:
  - LED_ROW 0..N_LED_ROWS-1, each DISPLAY_TIME cycles.
  - SW_ROW 0..N_SW_ROWS-1, each SW_TIME cycles.
  - UPDATE, 1 cycle.
  - Frame length L = N_LED_ROWS*DISPLAY_TIME + N_SW_ROWS*SW_TIME + 1.
  - After UPDATE the sequence wraps to LED row 0.
- LED slot, offset t = 0..DISPLAY_TIME-1:
  - t=0: capture row r of led_data and capture led_bright; set led_row_o to one-hot r.
  - Mid-slot changes to led_data or led_bright have no effect until the next slot.
  - Drive window: PAUSE_TIME <= t < DISPLAY_TIME-PAUSE_TIME.
  - pwm_cnt resets to 0 at window start and increments mod 2^BRIGHT_BITS.
  - on = (bright_cap == all-ones) || (pwm_cnt < bright_cap).
  - col_oe = led_row_oe = window && on.
  - col_o = ~row_cap throughout the slot.
  - Outside the window both enables are 0.
  - bright_cap = 0 blanks the row entirely.
- Switch slot s:
  - sw_row_oe is one-hot s for the whole slot.
  - col_oe = 0 and led_row_oe = 0; led_row_o = 0.
  - col_i passes through a 2-flop synchroniser.
  - In the last slot cycle, raw[s] <= ~col_sync.
- UPDATE cycle, per bit b:
  - If raw[b] == sw_state[b], cnt[b] <= 0.
  - Else if cnt[b] == DB_FRAMES-1: sw_state[b] flips, cnt[b] <= 0, and sw_rise[b] <= 1 if the new value is 1.
  - Else cnt[b] <= cnt[b]+1.
  - sw_state, sw_rise and sw_valid are registered. They are visible from the cycle after UPDATE; sw_rise and sw_valid last exactly 1 cycle, then return to 0.
  - DB_FRAMES = 1 accepts a change in the first frame it is seen.
- frame_start is asserted in the cycle at LED row 0, t=0, including the first cycle after reset release.
- Never true in the same cycle: col_oe together with any sw_row_oe bit; led_row_oe together with any sw_row_oe bit.
- Reset mid-frame aborts immediately; no partial sw_valid is emitted.
- All counters are sized by $clog2 of their maxima; no overflow at the default parameters.

Test Plan:
Common parameters: N_LED_ROWS=2, N_SW_ROWS=2, N_COLS=4, DISPLAY_TIME=20, PAUSE_TIME=3, SW_TIME=6, DB_FRAMES=2, BRIGHT_BITS=2. Frame length L = 53.
1. led_data=8'hA5, led_bright=3:
   - Row 0: led_row_o=01, col_o=4'hA; col_oe=1 exactly at offsets 3..16 (14 cycles).
   - Row 1: led_row_o=10, col_o=4'h5.
   - frame_start every 53 cycles.
2. led_bright=1:
   - In each drive window, col_oe is high 1 cycle in every 4 (pwm_cnt=0).
   - led_bright=0: col_oe never asserts in LED slots.
   - led_bright changed mid-slot: the current slot is unaffected.
3. Hold col_i=4'b1110 during SW row 0 only, every frame:
   - sw_state[0] = 1 after the 2nd UPDATE; the sw_rise bit pulses once with sw_valid.
   - No sw_rise pulse in the 3rd frame.
4. Glitch: col_i bit 0 low in one frame only:
   - sw_state stays 0 and cnt returns to 0.
   - Release after a stable press: sw_state returns to 0 after 2 frames with no sw_rise.
5. Scan-phase exclusivity, checked every cycle:
   - Assertion: col_oe implies sw_row_oe == 0.
   - Assertion: at most one sw_row_oe bit set.
6. Pulse rst_n low mid SW row 1:
   - All outputs and sw_state are 0 asynchronously.
   - After release, the scan restarts at LED row 0 with frame_start; no sw_valid until a full 53-cycle frame completes.
